// File: rtl/mux_pkg.sv
//------------------------------------------------------------------------------
// Module   : mux_pkg
// Purpose  : Shared constants and helpers for the round-robin multiplexer
//            family: default data width, channel-index width helper and
//            reset values for the output data and select registers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

    localparam int MUX_DEFAULT_W = 64;

    // Reset values of the output register fields (zero-extended at use site)
    localparam int MUX_RST_DATA  = 0;
    localparam int MUX_RST_SEL   = 0;

    // Width needed to encode 'value' distinct indices; never less than 1 so
    // that index vectors always have a legal range.
    function automatic int mux_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Purpose  : Purely combinational round-robin arbiter. Grants the first
//            asserted request found searching upward from 'ptr', wrapping
//            from N-1 to 0. No request gives an all-zero grant.
// Ports    : req[N]        - request vector
//            ptr[SW]       - highest-priority channel index (must be < N)
//            grant[N]      - one-hot grant (or zero)
//            grant_idx[SW] - encoded grant index (0 when no grant)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = mux_clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx
);

    int   w_pos;
    logic w_found;

    // Walk the N positions starting at ptr; the wrap is an explicit subtract
    // so that non-power-of-two N never produces an out-of-range index.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!w_found && req[w_pos[SW-1:0]]) begin
                w_found               = 1'b1;
                grant[w_pos[SW-1:0]]  = 1'b1;
                grant_idx             = w_pos[SW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_n.sv
//------------------------------------------------------------------------------
// Module   : mux_rr_n
// Purpose  : N-channel, W-bit registered multiplexer with valid/ready
//            handshakes and round-robin arbitration. The selected word is
//            held in an output register until the consumer accepts it;
//            drain and reload in the same cycle give one beat per cycle.
// Options  : MUX_RR_LOCK_EN - packet lock. Adds in_last; after a non-last
//            beat the grant stays on that channel until its last beat.
// Ports    : clk, rst_n (async, active-low)
//            in_data[N*W]  - channel i at [i*W +: W]
//            in_valid[N]   - per-channel request
//            in_ready[N]   - per-channel accept (combinational, one-hot/zero)
//            in_last[N]    - end-of-packet flag (MUX_RR_LOCK_EN only)
//            out_data[W], out_valid, out_sel[SW] - registered output
//            out_ready     - downstream accept
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_rr_n
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = MUX_DEFAULT_W,
    localparam int SW = mux_clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
`ifdef MUX_RR_LOCK_EN
    input  logic [N-1:0]   in_last,
`endif
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    localparam logic [SW-1:0] c_last_idx = SW'(N - 1);

    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic [SW-1:0] r_out_sel;
    logic [SW-1:0] r_ptr;

    logic [W-1:0]  w_ch [N];
    logic [N-1:0]  w_arb_grant;
    logic [SW-1:0] w_arb_idx;
    logic [N-1:0]  w_grant;
    logic [SW-1:0] w_gidx;
    logic [N-1:0]  w_in_ready;
    logic          w_load;
    logic          w_in_fire;
    logic [SW-1:0] w_ptr_next;

    // Split the flat input bus into per-channel words
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign w_ch[i] = in_data[i*W +: W];
    end

    rr_arbiter #(
        .N         (N)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_ptr),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx)
    );

`ifdef MUX_RR_LOCK_EN
    logic r_locked;

    // While locked the owner is the channel of the previous transfer, which
    // out_sel still holds; if the owner drops valid nobody else is granted.
    always_comb begin
        w_grant = w_arb_grant;
        w_gidx  = w_arb_idx;
        if (r_locked) begin
            w_grant            = '0;
            w_grant[r_out_sel] = in_valid[r_out_sel];
            w_gidx             = r_out_sel;
        end
    end
`else
    assign w_grant = w_arb_grant;
    assign w_gidx  = w_arb_idx;
`endif

    // Register is empty or being drained this cycle
    assign w_load     = !r_out_valid || out_ready;
    assign w_in_ready = w_grant & {N{w_load}};
    assign w_in_fire  = |w_in_ready;
    assign w_ptr_next = (w_gidx == c_last_idx) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= W'(MUX_RST_DATA);
            r_out_sel   <= SW'(MUX_RST_SEL);
            r_ptr       <= '0;
`ifdef MUX_RR_LOCK_EN
            r_locked    <= 1'b0;
`endif
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_ch[w_gidx];
            r_out_sel   <= w_gidx;
`ifdef MUX_RR_LOCK_EN
            // Pointer only moves when a packet completes
            if (in_last[w_gidx]) begin
                r_locked <= 1'b0;
                r_ptr    <= w_ptr_next;
            end else begin
                r_locked <= 1'b1;
            end
`else
            r_ptr       <= w_ptr_next;
`endif
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_n.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_rr_n
// Purpose  : Self-checking bench for mux_rr_n (N=4/W=64 and N=3/W=8).
//            A behavioural round-robin model predicts in_ready and pushes
//            each accepted beat to a scoreboard queue; beats are popped and
//            compared as the DUT presents/drains them. MUX_RR_LOCK_EN adds
//            the packet-lock scenario.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_rr_n;

    typedef struct {
        int          sel;
        logic [63:0] data;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;

    logic [4*64-1:0] in_data;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic [3:0]      in_last;
    logic [63:0]     out_data;
    logic            out_valid;
    logic [1:0]      out_sel;
    logic            out_ready;

    logic [3*8-1:0]  in_data3;
    logic [2:0]      in_valid3;
    logic [2:0]      in_ready3;
    logic [2:0]      in_last3;
    logic [7:0]      out_data3;
    logic            out_valid3;
    logic [1:0]      out_sel3;
    logic            out_ready3;

    int    n_checks = 0;
    int    n_errors = 0;

    int    m_ptr;
    bit    m_ov;
    bit    m_locked;
    int    m_lsel;
    beat_t sb[$];

    always #5 clk = ~clk;

    mux_rr_n #(.N(4), .W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MUX_RR_LOCK_EN
        .in_last   (in_last),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    mux_rr_n #(.N(3), .W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
`ifdef MUX_RR_LOCK_EN
        .in_last   (in_last3),
`endif
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_sel   (out_sel3),
        .out_ready (out_ready3)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_data(input int ch, input logic [63:0] d);
        in_data[ch*64 +: 64] = d;
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_ov     = 1'b0;
        m_locked = 1'b0;
        m_lsel   = 0;
        sb.delete();
    endtask

    // One clock cycle for the N=4 DUT: called just after a falling edge with
    // inputs already driven; checks, updates the model, returns at next
    // falling edge.
    task automatic tick();
        int         g;
        int         c;
        bit         load;
        logic [3:0] exp_rdy;
        beat_t      b;
        #1;
        load = !m_ov || out_ready;
        g    = -1;
        if (m_locked) begin
            if (in_valid[m_lsel]) g = m_lsel;
        end else begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (g < 0 && in_valid[c]) g = c;
            end
        end
        exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            if (sb.size() == 0) begin
                chk("sb_depth", 64'(sb.size()), 64'd1);
            end else begin
                chk("out_data", out_data, sb[0].data);
                chk("out_sel", 64'(out_sel), 64'(sb[0].sel));
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (load && g >= 0) begin
            b.sel  = g;
            b.data = in_data[g*64 +: 64];
            sb.push_back(b);
            m_ov = 1'b1;
`ifdef MUX_RR_LOCK_EN
            if (in_last[g]) begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % 4;
            end else begin
                m_locked = 1'b1;
                m_lsel   = g;
            end
`else
            m_ptr = (g + 1) % 4;
`endif
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fair_seq[6] = '{0, 1, 2, 3, 0, 1};
        int n3_seq[4]   = '{1, 2, 0, 2};
        logic [2:0] n3_v[4] = '{3'b010, 3'b101, 3'b101, 3'b101};

        in_data    = '0;
        in_valid   = '0;
        in_last    = '1;
        out_ready  = 1'b1;
        in_data3   = {8'h12, 8'h11, 8'h10};
        in_valid3  = '0;
        in_last3   = '1;
        out_ready3 = 1'b1;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst0_valid", 64'(out_valid), 64'd0);
        chk("rst0_data", out_data, 64'd0);
        chk("rst0_sel", 64'(out_sel), 64'd0);
        chk("rst0_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;

        // Fairness: all valid, data = channel index
        for (int i = 0; i < 4; i++) set_data(i, 64'(i));
        in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("fair_valid", 64'(out_valid), 64'd1);
            chk("fair_sel", 64'(out_sel), 64'(fair_seq[i]));
        end

        // Drain, then hold ch1 in the register under backpressure
        in_valid = 4'b0000;
        tick();
        set_data(1, 64'h1111);
        set_data(2, 64'h2222);
        in_valid = 4'b0010;
        tick();
        chk("bp_load_sel", 64'(out_sel), 64'd1);
        out_ready = 1'b0;
        in_valid  = 4'b0110;
        set_data(1, 64'h9999);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", out_data, 64'h1111);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_swap_sel", 64'(out_sel), 64'd2);
        chk("bp_swap_data", out_data, 64'h2222);
        chk("bp_swap_valid", 64'(out_valid), 64'd1);

        // Stall with ch2 held, then reset mid-stall
        out_ready = 1'b0;
        in_valid  = 4'b0000;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_data", out_data, 64'd0);
        chk("rst_async_sel", 64'(out_sel), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_data(2, 64'hA5);
        in_valid  = 4'b0100;
        tick();
        chk("post_rst_data", out_data, 64'hA5);
        chk("post_rst_sel", 64'(out_sel), 64'd2);

        // Sparse: ch3 alone, then ch0+ch1 -> 3,0,1
        for (int i = 0; i < 4; i++) set_data(i, 64'h100 + 64'(i));
        in_valid = 4'b1000;
        tick();
        chk("sparse_sel_a", 64'(out_sel), 64'd3);
        in_valid = 4'b0011;
        tick();
        chk("sparse_sel_b", 64'(out_sel), 64'd0);
        tick();
        chk("sparse_sel_c", 64'(out_sel), 64'd1);
        in_valid = 4'b0000;
        tick();

`ifdef MUX_RR_LOCK_EN
        // Packet lock: move ptr to 1, then ch1 sends 3 beats with a gap
        in_last  = 4'b1111;
        in_valid = 4'b0001;
        tick();
        chk("lock_pre_sel", 64'(out_sel), 64'd0);
        in_valid = 4'b0111;
        in_last  = 4'b0101;
        tick();
        chk("lock_b1_sel", 64'(out_sel), 64'd1);
        tick();
        chk("lock_b2_sel", 64'(out_sel), 64'd1);
        in_valid = 4'b0101;
        tick();
        chk("lock_gap1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("lock_gap2_valid", 64'(out_valid), 64'd0);
        in_valid = 4'b0111;
        in_last  = 4'b1111;
        tick();
        chk("lock_b3_sel", 64'(out_sel), 64'd1);
        tick();
        chk("lock_next_sel", 64'(out_sel), 64'd2);
        in_valid = 4'b0000;
        tick();
`endif

        // N=3 wrap: ch1 first puts ptr at 2, then ch0+ch2 -> 2,0,2
        for (int i = 0; i < 4; i++) begin
            in_valid3 = n3_v[i];
            #1;
            @(posedge clk);
            @(negedge clk);
            chk("n3_valid", 64'(out_valid3), 64'd1);
            chk("n3_sel", 64'(out_sel3), 64'(n3_seq[i]));
            chk("n3_data", 64'(out_data3), 64'h10 + 64'(n3_seq[i]));
            chk("n3_range", 64'(out_sel3 < 2'd3), 64'd1);
        end
        in_valid3 = '0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
